// File: rtl/ifft_playback_driver.sv
// Inverse-FFT playback driver: loads a spectrum frame into the fft core, runs the inverse transform and
// plays the real part out of a ping-pong RAM on codec strobes. Optional: IFFT_UNDERRUN_HOLD_EN.
module ifft_playback_driver #(
    parameter int NB        = 18,
    parameter int LOG_DEPTH = 9,
    parameter int SHIFT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     bin_valid,
    output logic                     bin_ready,
    input  logic signed [NB-1:0]     bin_real,
    input  logic signed [NB-1:0]     bin_imag,
    input  logic                     sample_strobe,
    output logic signed [NB-1:0]     sample_out,
    output logic                     sample_out_valid,
    output logic                     underrun,
    output logic                     fft_start,
    output logic [3:0]               fft_log_depth,
    output logic                     fft_real_mode,
    output logic                     fft_direction,
    input  logic                     fft_done,
    output logic [LOG_DEPTH-1:0]     fft_address,
    output logic                     fft_write_enable,
    output logic [2*NB-1:0]          fft_write_data,
    output logic                     fft_read_enable,
    input  logic                     fft_read_valid,
    input  logic [2*NB-1:0]          fft_read_data,
    output logic [2:0]               state_dbg
);

    localparam int N = 1 << LOG_DEPTH;
    localparam logic [LOG_DEPTH-1:0] LAST = LOG_DEPTH'(N - 1);
    localparam logic [LOG_DEPTH-1:0] ONE  = LOG_DEPTH'(1);

    // Bin handshake: a bin moves on a rising edge where bin_valid and bin_ready are both high.
    typedef enum logic [2:0] {
        S_LOAD      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_WAIT_BANK = 3'd3,
        S_UNLOAD    = 3'd4
    } state_t;

    state_t                 state;
    logic [LOG_DEPTH-1:0]   load_cnt;
    logic [LOG_DEPTH-1:0]   issue_cnt;
    logic [LOG_DEPTH-1:0]   cap_cnt;
    logic [LOG_DEPTH-1:0]   play_idx;
    logic                   issue_done;
    logic [1:0]             bank_full;
    logic                   fill_bank;
    logic                   play_bank;
    logic signed [NB-1:0]   play_buf [0:2*N-1];

    logic                   bin_xfer;
    logic                   cap_fire;
    logic                   cap_last;
    logic                   play_last;
    logic [1:0]             set_mask;
    logic [1:0]             clr_mask;
    logic signed [NB-1:0]   cap_value;
    logic                   unused_imag;

    assign bin_xfer    = (state == S_LOAD) && bin_valid && bin_ready;
    assign cap_fire    = (state == S_UNLOAD) && fft_read_valid;
    assign cap_last    = cap_fire && (cap_cnt == LAST);
    assign play_last   = sample_strobe && bank_full[play_bank] && (play_idx == LAST);
    assign cap_value   = $signed(fft_read_data[NB-1:0]) >>> SHIFT;
    assign unused_imag = ^fft_read_data[2*NB-1:NB];

    assign fft_log_depth = 4'(LOG_DEPTH);
    assign fft_real_mode = 1'b0;
    assign fft_direction = 1'b1;
    assign state_dbg     = state;

    // Fill and drain always address opposite banks when they coincide, so both edits apply.
    always_comb begin
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (cap_last)  set_mask[fill_bank] = 1'b1;
        if (play_last) clr_mask[play_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (cap_fire) play_buf[{fill_bank, cap_cnt}] <= cap_value;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_LOAD;
            load_cnt         <= '0;
            issue_cnt        <= '0;
            cap_cnt          <= '0;
            issue_done       <= 1'b0;
            fill_bank        <= 1'b0;
            bin_ready        <= 1'b0;
            fft_start        <= 1'b0;
            fft_write_enable <= 1'b0;
            fft_write_data   <= '0;
            fft_read_enable  <= 1'b0;
            fft_address      <= '0;
        end else begin
            bin_ready        <= 1'b0;
            fft_start        <= 1'b0;
            fft_write_enable <= 1'b0;
            case (state)
                S_LOAD: begin
                    bin_ready <= !(bin_xfer && load_cnt == LAST);
                    if (bin_xfer) begin
                        fft_write_enable <= 1'b1;
                        fft_address      <= load_cnt;
                        fft_write_data   <= {bin_imag, bin_real};
                        load_cnt         <= load_cnt + ONE;
                        if (load_cnt == LAST) state <= S_START;
                    end
                end
                S_START: begin
                    fft_start <= 1'b1;
                    state     <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (fft_done) state <= bank_full[fill_bank] ? S_WAIT_BANK : S_UNLOAD;
                end
                S_WAIT_BANK: begin
                    if (!bank_full[fill_bank]) state <= S_UNLOAD;
                end
                S_UNLOAD: begin
                    // Issue and capture run independently; counters wrap back to 0 for the next frame.
                    if (!issue_done) begin
                        fft_read_enable <= 1'b1;
                        fft_address     <= issue_cnt;
                        issue_cnt       <= issue_cnt + ONE;
                        if (issue_cnt == LAST) issue_done <= 1'b1;
                    end else begin
                        fft_read_enable <= 1'b0;
                    end
                    if (cap_fire) cap_cnt <= cap_cnt + ONE;
                    if (cap_last) begin
                        fill_bank       <= ~fill_bank;
                        issue_done      <= 1'b0;
                        fft_read_enable <= 1'b0;
                        state           <= S_LOAD;
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bank_full        <= 2'b00;
            play_bank        <= 1'b0;
            play_idx         <= '0;
            sample_out       <= '0;
            sample_out_valid <= 1'b0;
            underrun         <= 1'b0;
        end else begin
            sample_out_valid <= sample_strobe;
            bank_full        <= (bank_full | set_mask) & ~clr_mask;
            if (sample_strobe) begin
                if (bank_full[play_bank]) begin
                    sample_out <= play_buf[{play_bank, play_idx}];
                    play_idx   <= play_idx + ONE;
                    if (play_idx == LAST) play_bank <= ~play_bank;
                end else begin
                    underrun <= 1'b1;
`ifdef IFFT_UNDERRUN_HOLD_EN
                    sample_out <= sample_out;
`else
                    sample_out <= '0;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_ifft_playback_driver.sv
// Bench for ifft_playback_driver: a behavioural fft core model, a write/sample scoreboard and scenario tasks.
module tb_ifft_playback_driver;
    localparam int NB = 18;
    localparam int LD = 9;
    localparam int N  = 1 << LD;
    localparam logic [2:0] ST_LOAD      = 3'd0;
    localparam logic [2:0] ST_WAIT_BANK = 3'd3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic              bin_valid = 1'b0;
    logic [NB-1:0]     bin_real  = '0;
    logic [NB-1:0]     bin_imag  = '0;
    logic              sample_strobe = 1'b0;
    logic              fft_done = 1'b0;
    logic              fft_read_valid = 1'b0;
    logic [2*NB-1:0]   fft_read_data = '0;

    logic              bin_ready, sample_out_valid, underrun, fft_start, fft_real_mode, fft_direction;
    logic              fft_write_enable, fft_read_enable;
    logic [NB-1:0]     sample_out;
    logic [3:0]        fft_log_depth;
    logic [LD-1:0]     fft_address;
    logic [2*NB-1:0]   fft_write_data;
    logic [2:0]        state_dbg;

    logic              s2_bin_ready, s2_sample_out_valid, s2_underrun, s2_fft_start, s2_fft_real_mode;
    logic              s2_fft_direction, s2_fft_write_enable, s2_fft_read_enable;
    logic [NB-1:0]     s2_sample_out;
    logic [3:0]        s2_fft_log_depth;
    logic [LD-1:0]     s2_fft_address;
    logic [2*NB-1:0]   s2_fft_write_data;
    logic [2:0]        s2_state_dbg;

    ifft_playback_driver #(.NB(NB), .LOG_DEPTH(LD), .SHIFT(0)) u_dut (
        .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_ready(bin_ready),
        .bin_real(bin_real), .bin_imag(bin_imag), .sample_strobe(sample_strobe),
        .sample_out(sample_out), .sample_out_valid(sample_out_valid), .underrun(underrun),
        .fft_start(fft_start), .fft_log_depth(fft_log_depth), .fft_real_mode(fft_real_mode),
        .fft_direction(fft_direction), .fft_done(fft_done), .fft_address(fft_address),
        .fft_write_enable(fft_write_enable), .fft_write_data(fft_write_data),
        .fft_read_enable(fft_read_enable), .fft_read_valid(fft_read_valid),
        .fft_read_data(fft_read_data), .state_dbg(state_dbg)
    );

    // Same stimulus, SHIFT=2; its fft handshake timing is identical so it shares the core model.
    ifft_playback_driver #(.NB(NB), .LOG_DEPTH(LD), .SHIFT(2)) u_s2 (
        .clk(clk), .reset(reset), .bin_valid(bin_valid), .bin_ready(s2_bin_ready),
        .bin_real(bin_real), .bin_imag(bin_imag), .sample_strobe(sample_strobe),
        .sample_out(s2_sample_out), .sample_out_valid(s2_sample_out_valid), .underrun(s2_underrun),
        .fft_start(s2_fft_start), .fft_log_depth(s2_fft_log_depth), .fft_real_mode(s2_fft_real_mode),
        .fft_direction(s2_fft_direction), .fft_done(fft_done), .fft_address(s2_fft_address),
        .fft_write_enable(s2_fft_write_enable), .fft_write_data(s2_fft_write_data),
        .fft_read_enable(s2_fft_read_enable), .fft_read_valid(fft_read_valid),
        .fft_read_data(fft_read_data), .state_dbg(s2_state_dbg)
    );

    // fft core model: read returns real=address (or -address), imag=0, latency 2; done ~20 cycles after start.
    int            model_mode   = 0;
    int            done_cnt     = 0;
    int            start_pulses = 0;
    int            cap_pulses   = 0;
    logic          v1 = 1'b0;
    logic [LD-1:0] a1 = '0;

    function automatic logic [NB-1:0] model_real(input logic [LD-1:0] a);
        int v;
        v = int'(a);
        if (model_mode != 0) v = -v;
        return NB'(v);
    endfunction

    always @(posedge clk) begin
        v1             <= fft_read_enable;
        a1             <= fft_address;
        fft_read_valid <= v1;
        fft_read_data  <= {{NB{1'b0}}, model_real(a1)};
        fft_done       <= 1'b0;
        if (fft_start) begin
            done_cnt     <= 20;
            start_pulses <= start_pulses + 1;
        end else if (done_cnt != 0) begin
            done_cnt <= done_cnt - 1;
            if (done_cnt == 1) fft_done <= 1'b1;
        end
        if (fft_read_valid) cap_pulses <= cap_pulses + 1;
    end

    int checks   = 0;
    int failures = 0;
    logic [LD+2*NB-1:0] wr_q[$];
    logic [NB-1:0]      exp_q[$];
    logic [NB-1:0]      exp_s2_q[$];

    // Advance to the next falling edge and retire any write or sample the DUT produced.
    task automatic tick();
        logic [LD+2*NB-1:0] ew;
        logic [NB-1:0]      es;
        @(negedge clk);
        if (fft_write_enable) begin
            checks++;
            if (wr_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got addr=%0d data=%h", fft_address, fft_write_data);
            end else begin
                ew = wr_q.pop_front();
                if ({fft_address, fft_write_data} !== ew) begin
                    failures++;
                    $display("FAIL write got=%h expected=%h", {fft_address, fft_write_data}, ew);
                end
            end
        end
        if (sample_out_valid) begin
            checks++;
            if (exp_q.size() == 0 || exp_s2_q.size() == 0) begin
                failures++;
                $display("FAIL sample_unexpected got=%h", sample_out);
            end else begin
                es = exp_q.pop_front();
                if (sample_out !== es) begin
                    failures++;
                    $display("FAIL sample got=%h expected=%h", sample_out, es);
                end
                es = exp_s2_q.pop_front();
                checks++;
                if (s2_sample_out !== es || s2_sample_out_valid !== 1'b1) begin
                    failures++;
                    $display("FAIL sample_shift2 got=%h expected=%h", s2_sample_out, es);
                end
            end
        end
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        bin_valid     = 1'b0;
        sample_strobe = 1'b0;
        repeat (3) tick();
        wr_q.delete();
        exp_q.delete();
        exp_s2_q.delete();
        reset = 1'b1;
        tick();
    endtask

    task automatic send_frame();
        int w;
        for (int k = 0; k < N; k++) begin
            bin_valid = 1'b1;
            bin_real  = NB'($urandom);
            bin_imag  = NB'($urandom);
            wr_q.push_back({LD'(k), bin_imag, bin_real});
            w = 0;
            while (bin_ready !== 1'b1 && w < 3000) begin
                tick();
                w++;
            end
            if (w >= 3000) begin
                checks++;
                failures++;
                $display("FAIL bin_ready_timeout bin=%0d", k);
                bin_valid = 1'b0;
                wr_q.delete();
                return;
            end
            tick();
        end
        bin_valid = 1'b0;
    endtask

    task automatic wait_loaded_again(input string name);
        int w;
        w = 0;
        while (bin_ready !== 1'b1 && w < 3000) begin
            tick();
            w++;
        end
        checks++;
        if (bin_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s timeout waiting for bin_ready got=%b expected=1", name, bin_ready);
        end
    endtask

    task automatic strobe_once(input logic [NB-1:0] e, input logic [NB-1:0] e2);
        exp_q.push_back(e);
        exp_s2_q.push_back(e2);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    task automatic play(input int n, input int gap, input int neg);
        int v;
        for (int k = 0; k < n; k++) begin
            v = (neg != 0) ? -k : k;
            strobe_once(NB'(v), NB'(v >>> 2));
            repeat (gap - 1) tick();
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL play_drain got=%0d pending expected=0", exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        checks++;
        if ({bin_ready, fft_start, fft_write_enable, fft_read_enable, sample_out_valid, underrun} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b expected=000000",
                     {bin_ready, fft_start, fft_write_enable, fft_read_enable, sample_out_valid, underrun});
        end
        checks++;
        if (sample_out !== '0 || state_dbg !== ST_LOAD) begin
            failures++;
            $display("FAIL reset_data got sample=%h state=%0d expected 0/0", sample_out, state_dbg);
        end
        checks++;
        if ({fft_log_depth, fft_real_mode, fft_direction} !== 6'b1001_01) begin
            failures++;
            $display("FAIL const_ports got=%b expected=100101", {fft_log_depth, fft_real_mode, fft_direction});
        end
        reset = 1'b1;
        tick();
        checks++;
        if (bin_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got=%b expected=1", bin_ready);
        end
    endtask

    task automatic test_underrun_first();
        do_reset();
        strobe_once('0, '0);
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_set got=%b expected=1", underrun);
        end
        repeat (6) tick();
        checks++;
        if (underrun !== 1'b1 || sample_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL underrun_sticky got=%b valid=%b expected 1/0", underrun, sample_out_valid);
        end
    endtask

    task automatic test_playback();
        int base;
        do_reset();
        base = start_pulses;
        send_frame();
        wait_loaded_again("playback");
        checks++;
        if (start_pulses - base != 1) begin
            failures++;
            $display("FAIL start_pulses got=%0d expected=1", start_pulses - base);
        end
        play(N, 8, 0);
        checks++;
        if (underrun !== 1'b0) begin
            failures++;
            $display("FAIL playback_underrun got=%b expected=0", underrun);
        end
`ifdef IFFT_UNDERRUN_HOLD_EN
        strobe_once(NB'(N - 1), NB'((N - 1) >>> 2));
`else
        strobe_once('0, '0);
`endif
        checks++;
        if (underrun !== 1'b1) begin
            failures++;
            $display("FAIL underrun_after_frame got=%b expected=1", underrun);
        end
    endtask

    task automatic test_three_frames();
        int base;
        int w;
        do_reset();
        base = start_pulses;
        send_frame();
        send_frame();
        send_frame();
        w = 0;
        while (state_dbg !== ST_WAIT_BANK && w < 200) begin
            tick();
            w++;
        end
        repeat (50) tick();
        checks++;
        if (state_dbg !== ST_WAIT_BANK || bin_ready !== 1'b0 || fft_read_enable !== 1'b0) begin
            failures++;
            $display("FAIL wait_bank got state=%0d ready=%b re=%b expected 3/0/0",
                     state_dbg, bin_ready, fft_read_enable);
        end
        play(N, 4, 0);
        wait_loaded_again("three_frames");
        checks++;
        if (underrun !== 1'b0 || start_pulses - base != 3) begin
            failures++;
            $display("FAIL three_frames got underrun=%b starts=%0d expected 0/3", underrun, start_pulses - base);
        end
    endtask

    task automatic test_reset_mid_capture();
        int base;
        int w;
        do_reset();
        send_frame();
        base = cap_pulses;
        w = 0;
        while (cap_pulses - base < 200 && w < 1000) begin
            tick();
            w++;
        end
        checks++;
        if (cap_pulses - base < 200 || fft_read_enable !== 1'b1) begin
            failures++;
            $display("FAIL reach_capture_200 got=%0d re=%b expected>=200/1", cap_pulses - base, fft_read_enable);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bin_ready, fft_start, fft_write_enable, fft_read_enable, sample_out_valid, underrun} !== 6'b0 ||
            sample_out !== '0 || state_dbg !== ST_LOAD) begin
            failures++;
            $display("FAIL async_reset got ctrl=%b sample=%h state=%0d expected all 0",
                     {bin_ready, fft_start, fft_write_enable, fft_read_enable, sample_out_valid, underrun},
                     sample_out, state_dbg);
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        strobe_once('0, '0);
        checks++;
        if (underrun !== 1'b1 || bin_ready !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_underrun got underrun=%b ready=%b expected 1/1", underrun, bin_ready);
        end
    endtask

    task automatic test_shift_negative();
        do_reset();
        model_mode = 1;
        send_frame();
        wait_loaded_again("shift");
        play(N, 2, 1);
        model_mode = 0;
        checks++;
        if (underrun !== 1'b0 || s2_underrun !== 1'b0) begin
            failures++;
            $display("FAIL shift_underrun got=%b/%b expected 0/0", underrun, s2_underrun);
        end
    endtask

    initial begin
        test_reset();
        test_underrun_first();
        test_playback();
        test_three_frames();
        test_reset_mid_capture();
        test_shift_negative();
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
